mc_controller: RTL and testbench

Multicycle successor to the single-cycle MIPS control unit: a Moore FSM plus ALU decoder that sequences each instruction over 3–5+ cycles and shares one ALU and one memory port. It sits beside the multicycle datapath, takes opcode/funct from the instruction register and the ALU zero flag, and drives all datapath enables and muxes. Unlike the single-cycle unit, it stalls on a memory ready handshake and times out hung accesses.

---
 rtl/mc_ctrl_pkg.sv | 47 ++++
 rtl/mc_aludec.sv | 35 +++
 rtl/mc_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_mc_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and constants for the multicycle MIPS controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT,
        ALUOP_OR
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_SLT = 4'b0111;

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - combinational ALU decoder: aluop + funct to alucontrol
module mc_aludec
    import mc_ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [3:0]  alucontrol,
    output logic        illegal_funct
);

    // Unknown R-type functs fall back to ADD so writeback stays well defined
    always_comb begin
        alucontrol    = ALUC_ADD;
        illegal_funct = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_OR:  alucontrol = ALUC_OR;
            default: begin
                case (funct)
                    FN_ADD:  alucontrol = ALUC_ADD;
                    FN_SUB:  alucontrol = ALUC_SUB;
                    FN_AND:  alucontrol = ALUC_AND;
                    FN_OR:   alucontrol = ALUC_OR;
                    FN_SLT:  alucontrol = ALUC_SLT;
                    default: begin
                        alucontrol    = ALUC_ADD;
                        illegal_funct = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM with memory watchdog (option: MC_CTRL_BNE_EN adds bne/ori)
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUCTRL_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 memwrite,
    output logic                 iord,
    output logic                 irwrite,
    output logic                 pcen,
    output logic                 regwrite,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal_op,
    output logic                 mem_err
);

    localparam int WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t          state;
    state_t          state_nx;
    logic [WD_W-1:0] wd_cnt;
    logic            is_sw;
    logic            in_mem;
    logic            wd_expire;
    logic            op_legal;
    aluop_t          aluop;
    logic [3:0]      alu_raw;
    logic            illegal_funct;
`ifdef MC_CTRL_BNE_EN
    logic            alt_op;
`endif

    assign in_mem    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // mem_ready in the expiry cycle wins over the timeout
    assign wd_expire = (MEM_TIMEOUT != 0) && in_mem && !mem_ready
                       && (wd_cnt == WD_W'(MEM_TIMEOUT));

    // Opcodes this build understands; anything else is reported in DECODE
    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
`ifdef MC_CTRL_BNE_EN
            OP_BNE, OP_ORI: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    end

    // Next-state selection; memory states hold until ready or watchdog expiry
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)      state_nx = S_DECODE;
                else if (wd_expire) state_nx = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_EXECUTE;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_ADDI:      state_nx = S_ADDIEXEC;
                    OP_J:         state_nx = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_nx = S_BRANCH;
                    OP_ORI:       state_nx = S_ADDIEXEC;
`endif
                    default:      state_nx = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nx = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)      state_nx = S_MEMWB;
                else if (wd_expire) state_nx = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready || wd_expire) state_nx = S_FETCH;
            end
            S_EXECUTE:  state_nx = S_ALUWB;
            S_ADDIEXEC: state_nx = S_ADDIWB;
            default:    state_nx = S_FETCH;
        endcase
    end

    // State register, watchdog counter and opcode flags latched in DECODE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            wd_cnt <= '0;
            is_sw  <= 1'b0;
`ifdef MC_CTRL_BNE_EN
            alt_op <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if ((state_nx != state) || wd_expire)
                wd_cnt <= '0;
            else if (in_mem && !mem_ready)
                wd_cnt <= wd_cnt + WD_W'(1);
            if (state == S_DECODE) begin
                is_sw  <= (op == OP_SW);
`ifdef MC_CTRL_BNE_EN
                alt_op <= (op == OP_BNE) || (op == OP_ORI);
`endif
            end
        end
    end

    // Moore output decode; reset masks every enable and pulse
    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = !op_legal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                illegal_op = illegal_funct;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
`ifdef MC_CTRL_BNE_EN
                pcen    = alt_op ? !zero : zero;
`else
                pcen    = zero;
`endif
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
`ifdef MC_CTRL_BNE_EN
                aluop   = alt_op ? ALUOP_OR : ALUOP_ADD;
`endif
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        mem_err = wd_expire;
        if (reset) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            pcen       = 1'b0;
            regwrite   = 1'b0;
            illegal_op = 1'b0;
            mem_err    = 1'b0;
        end
    end

    mc_aludec u_aludec (
        .aluop         (aluop),
        .funct         (funct),
        .alucontrol    (alu_raw),
        .illegal_funct (illegal_funct)
    );

    assign alucontrol = ALUCTRL_W'(alu_raw);

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite;
    logic       memtoreg, regdst, alusrca, illegal_op, mem_err;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol;

    int n_cmp = 0;
    int n_fail = 0;

    mc_controller #(.MEM_TIMEOUT(16), .ALUCTRL_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal_op (illegal_op),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Fetch with zero wait, leaving the FSM in DECODE
    task automatic fetch_now(input logic [5:0] o);
        op = o;
        mem_ready = 1'b1;
        #1;
        tick;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_cmp++; if ({mem_req, irwrite, pcen, regwrite, memwrite, illegal_op, mem_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_enables got %b want 0000000", {mem_req, irwrite, pcen, regwrite, memwrite, illegal_op, mem_err}); end
        n_cmp++; if ({alusrcb, iord, alusrca, pcsrc, alucontrol} !== 10'b01_0_0_00_0010) begin
            n_fail++; $display("FAIL reset_fetch_vals got %b want 0100000010", {alusrcb, iord, alusrca, pcsrc, alucontrol}); end
        tick;
        n_cmp++; if ({mem_req, irwrite, pcen} !== 3'b000) begin
            n_fail++; $display("FAIL reset_held got %b want 000", {mem_req, irwrite, pcen}); end
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_cmp++; if ({mem_req, iord, irwrite, pcen} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_release got %b want 1000", {mem_req, iord, irwrite, pcen}); end
    endtask

    task automatic test_lw;
        op = 6'b100011;
        mem_ready = 1'b1;
        #1;
        n_cmp++; if ({mem_req, iord, irwrite, pcen} !== 4'b1011) begin
            n_fail++; $display("FAIL lw_fetch got %b want 1011", {mem_req, iord, irwrite, pcen}); end
        tick;
        #1;
        n_cmp++; if ({pcen, irwrite, alusrcb, alucontrol, illegal_op} !== 9'b0_0_11_0010_0) begin
            n_fail++; $display("FAIL lw_decode got %b want 001100100", {pcen, irwrite, alusrcb, alucontrol, illegal_op}); end
        tick;
        #1;
        n_cmp++; if ({alusrca, alusrcb, mem_req, pcen} !== 5'b1_10_0_0) begin
            n_fail++; $display("FAIL lw_memadr got %b want 11000", {alusrca, alusrcb, mem_req, pcen}); end
        tick;
        #1;
        n_cmp++; if ({mem_req, iord, memwrite, regwrite, pcen} !== 5'b11000) begin
            n_fail++; $display("FAIL lw_memrd got %b want 11000", {mem_req, iord, memwrite, regwrite, pcen}); end
        tick;
        mem_ready = 1'b0;
        #1;
        n_cmp++; if ({regwrite, memtoreg, regdst, pcen, mem_req} !== 5'b11000) begin
            n_fail++; $display("FAIL lw_memwb got %b want 11000", {regwrite, memtoreg, regdst, pcen, mem_req}); end
        tick;
        n_cmp++; if ({mem_req, iord, irwrite, alusrcb} !== 5'b100_01) begin
            n_fail++; $display("FAIL lw_refetch got %b want 10001", {mem_req, iord, irwrite, alusrcb}); end
    endtask

    task automatic test_fetch_stall_jump;
        int nreq = 0;
        int npulse = 0;
        int pulse_at = -1;
        op = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            if (mem_req) nreq++;
            if (irwrite || pcen) begin
                npulse++;
                pulse_at = i;
            end
            tick;
        end
        mem_ready = 1'b0;
        n_cmp++; if (nreq !== 4) begin
            n_fail++; $display("FAIL stall_memreq_cycles got %0d want 4", nreq); end
        n_cmp++; if ({npulse, pulse_at} !== {32'd1, 32'd3}) begin
            n_fail++; $display("FAIL stall_pulse got count %0d at %0d want 1 at 3", npulse, pulse_at); end
        #1;
        n_cmp++; if ({illegal_op, alusrcb} !== 3'b0_11) begin
            n_fail++; $display("FAIL j_decode got %b want 011", {illegal_op, alusrcb}); end
        tick;
        n_cmp++; if ({pcen, pcsrc, regwrite} !== 4'b1_10_0) begin
            n_fail++; $display("FAIL j_jump got %b want 1100", {pcen, pcsrc, regwrite}); end
        tick;
        n_cmp++; if ({mem_req, iord, pcsrc} !== 4'b10_00) begin
            n_fail++; $display("FAIL j_refetch got %b want 1000", {mem_req, iord, pcsrc}); end
    endtask

    task automatic test_beq(input logic z, input logic exp_pcen);
        zero = z;
        fetch_now(6'b000100);
        tick;
        n_cmp++; if ({pcen, pcsrc, alusrca, alusrcb, alucontrol} !== {exp_pcen, 2'b01, 1'b1, 2'b00, 4'b0110}) begin
            n_fail++; $display("FAIL beq_branch_z%0d got %b want %b", z, {pcen, pcsrc, alusrca, alusrcb, alucontrol}, {exp_pcen, 9'b01_1_00_0110}); end
        tick;
        n_cmp++; if ({mem_req, iord, alusrcb, pcsrc} !== 6'b10_01_00) begin
            n_fail++; $display("FAIL beq_refetch_z%0d got %b want 100100", z, {mem_req, iord, alusrcb, pcsrc}); end
    endtask

    task automatic test_rtype(input logic [5:0] f, input logic [3:0] exp_alu, input logic exp_ill);
        funct = f;
        fetch_now(6'b000000);
        tick;
        n_cmp++; if ({alucontrol, illegal_op, alusrca, alusrcb, regwrite} !== {exp_alu, exp_ill, 4'b1_00_0}) begin
            n_fail++; $display("FAIL rtype_exec_%b got %b want %b", f, {alucontrol, illegal_op, alusrca, alusrcb, regwrite}, {exp_alu, exp_ill, 4'b1000}); end
        tick;
        n_cmp++; if ({regwrite, regdst, memtoreg, illegal_op} !== 4'b1100) begin
            n_fail++; $display("FAIL rtype_wb_%b got %b want 1100", f, {regwrite, regdst, memtoreg, illegal_op}); end
        tick;
        n_cmp++; if ({mem_req, iord, regwrite} !== 3'b100) begin
            n_fail++; $display("FAIL rtype_refetch_%b got %b want 100", f, {mem_req, iord, regwrite}); end
    endtask

    task automatic test_addi;
        fetch_now(6'b001000);
        tick;
        n_cmp++; if ({alusrca, alusrcb, alucontrol, regwrite} !== 8'b1_10_0010_0) begin
            n_fail++; $display("FAIL addi_exec got %b want 11000100", {alusrca, alusrcb, alucontrol, regwrite}); end
        tick;
        n_cmp++; if ({regwrite, regdst, memtoreg} !== 3'b100) begin
            n_fail++; $display("FAIL addi_wb got %b want 100", {regwrite, regdst, memtoreg}); end
        tick;
        n_cmp++; if ({mem_req, iord} !== 2'b10) begin
            n_fail++; $display("FAIL addi_refetch got %b want 10", {mem_req, iord}); end
    endtask

    task automatic test_sw;
        fetch_now(6'b101011);
        tick;
        tick;
        mem_ready = 1'b1;
        #1;
        n_cmp++; if ({mem_req, memwrite, iord, regwrite} !== 4'b1110) begin
            n_fail++; $display("FAIL sw_memwr got %b want 1110", {mem_req, memwrite, iord, regwrite}); end
        tick;
        mem_ready = 1'b0;
        #1;
        n_cmp++; if ({mem_req, memwrite, iord} !== 3'b100) begin
            n_fail++; $display("FAIL sw_refetch got %b want 100", {mem_req, memwrite, iord}); end
    endtask

    task automatic test_timeout(input logic ready_at_expiry);
        int  err_at = -1;
        int  cycles = 0;
        logic rw = 1'b0;
        logic done;
        fetch_now(6'b100011);
        tick;
        tick;
        for (int i = 0; i < 40; i++) begin
            mem_ready = ready_at_expiry && (i == 16);
            #1;
            if (regwrite) rw = 1'b1;
            if (mem_err && err_at < 0) err_at = i;
            done = mem_err || mem_ready;
            cycles = i + 1;
            tick;
            if (done) break;
        end
        mem_ready = 1'b0;
        if (ready_at_expiry) begin
            n_cmp++; if (err_at !== -1 || cycles !== 17) begin
                n_fail++; $display("FAIL wd_ready_at_expiry got err_at %0d cycles %0d want -1 17", err_at, cycles); end
            n_cmp++; if ({regwrite, memtoreg, mem_err} !== 3'b110) begin
                n_fail++; $display("FAIL wd_ready_memwb got %b want 110", {regwrite, memtoreg, mem_err}); end
            tick;
        end else begin
            n_cmp++; if (err_at !== 16) begin
                n_fail++; $display("FAIL wd_timeout_cycle got %0d want 16", err_at); end
            n_cmp++; if ({rw, regwrite, mem_req, iord, mem_err} !== 5'b00100) begin
                n_fail++; $display("FAIL wd_timeout_refetch got %b want 00100", {rw, regwrite, mem_req, iord, mem_err}); end
        end
    endtask

    task automatic test_bne_op;
        zero = 1'b0;
        fetch_now(6'b000101);
        #1;
`ifdef MC_CTRL_BNE_EN
        n_cmp++; if (illegal_op !== 1'b0) begin
            n_fail++; $display("FAIL bne_decode got %b want 0", illegal_op); end
        tick;
        n_cmp++; if ({pcen, pcsrc} !== 3'b1_01) begin
            n_fail++; $display("FAIL bne_branch got %b want 101", {pcen, pcsrc}); end
        tick;
`else
        n_cmp++; if (illegal_op !== 1'b1) begin
            n_fail++; $display("FAIL bne_illegal got %b want 1", illegal_op); end
        tick;
        n_cmp++; if ({mem_req, iord, illegal_op, pcen} !== 4'b1000) begin
            n_fail++; $display("FAIL bne_refetch got %b want 1000", {mem_req, iord, illegal_op, pcen}); end
`endif
    endtask

    task automatic test_reset_midwrite;
        fetch_now(6'b101011);
        tick;
        tick;
        #1;
        n_cmp++; if ({memwrite, mem_req} !== 2'b11) begin
            n_fail++; $display("FAIL rst_memwr_before got %b want 11", {memwrite, mem_req}); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({memwrite, mem_req, regwrite} !== 3'b000) begin
            n_fail++; $display("FAIL rst_memwr_drop got %b want 000", {memwrite, mem_req, regwrite}); end
        tick;
        reset = 1'b0;
        #1;
        n_cmp++; if ({mem_req, iord, memwrite, alusrcb} !== 5'b100_01) begin
            n_fail++; $display("FAIL rst_refetch got %b want 10001", {mem_req, iord, memwrite, alusrcb}); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if ({irwrite, pcen} !== 2'b11) begin
            n_fail++; $display("FAIL rst_fetch_ready got %b want 11", {irwrite, pcen}); end
        tick;
        mem_ready = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset;
        test_lw;
        test_fetch_stall_jump;
        test_beq(1'b1, 1'b1);
        test_beq(1'b0, 1'b0);
        test_rtype(6'b101010, 4'b0111, 1'b0);
        test_rtype(6'b111111, 4'b0010, 1'b1);
        test_rtype(6'b100100, 4'b0000, 1'b0);
        test_addi;
        test_sw;
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_bne_op;
        test_reset_midwrite;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
